// File: rtl/button_press_pulse_pkg.sv
// Shared helpers for the button_press_pulse slice.
// Holds the lockout counter sizing rule.
package button_press_pulse_pkg;

  // Bits needed to hold 0..max_val, never fewer than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_press_pulse_sync_chain.sv
// Reusable multi-flop synchronizer for a single asynchronous level.
// Cleared asynchronously so a stale level cannot survive reset.
module sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] s_q;
  logic [STAGES-1:0] s_d;

  always_comb begin
    s_d = {s_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

  assign q = s_q[STAGES-1];

endmodule

// File: rtl/button_press_pulse.sv
// One-cycle pulse per accepted rising edge of a debounced button level,
// with a synchronizer in front and an optional re-trigger lockout window.
module button_press_pulse
  import button_press_pulse_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned LOCKOUT_CYCLES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  localparam int unsigned CW = cnt_width(LOCKOUT_CYCLES);

  logic          s_last;
  logic          rise;
  logic          prev_q;
  logic          out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (in),
    .q    (s_last)
  );

  // Edges arriving while the counter is nonzero are dropped, not deferred.
  always_comb begin
    rise  = s_last & ~prev_q;
    out_d = 1'b0;
    cnt_d = cnt_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
    if (rise && (cnt_q == '0)) begin
      out_d = 1'b1;
      cnt_d = CW'(LOCKOUT_CYCLES);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= 1'b0;
      out_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      prev_q <= s_last;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_button_press_pulse.sv
// Bench for button_press_pulse: three parameterisations share one stimulus
// and are checked against a sample-history reference model.
module tb_button_press_pulse;

  localparam int S_CFG [3] = '{2, 2, 4};
  localparam int L_CFG [3] = '{0, 8, 3};

  logic clk;
  logic reset;
  logic btn;
  logic o0, o1, o2;

  int errors = 0;
  int checks = 0;

  button_press_pulse #(.SYNC_STAGES(S_CFG[0]), .LOCKOUT_CYCLES(L_CFG[0])) u0 (
    .clk(clk), .reset(reset), .in(btn), .out(o0));
  button_press_pulse #(.SYNC_STAGES(S_CFG[1]), .LOCKOUT_CYCLES(L_CFG[1])) u1 (
    .clk(clk), .reset(reset), .in(btn), .out(o1));
  button_press_pulse #(.SYNC_STAGES(S_CFG[2]), .LOCKOUT_CYCLES(L_CFG[2])) u2 (
    .clk(clk), .reset(reset), .in(btn), .out(o2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: hist[0] is the level sampled at this edge, hist[n] n edges ago.
  // An edge is detected S edges after the first high sample that follows a low
  // one; it is accepted if more than L edges have passed since the last accept.
  logic [7:0] hist = '0;
  logic [2:0] exp_o = '0;
  int cyc = 0;
  int last_acc [3] = '{-1000, -1000, -1000};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset) begin
      hist  <= '0;
      exp_o <= '0;
      for (int i = 0; i < 3; i++) last_acc[i] <= -1000;
    end else begin
      hist <= {hist[6:0], btn};
      for (int i = 0; i < 3; i++) begin
        if (hist[S_CFG[i]-1] && !hist[S_CFG[i]] && (cyc - last_acc[i] > L_CFG[i])) begin
          exp_o[i]    <= 1'b1;
          last_acc[i] <= cyc;
        end else begin
          exp_o[i] <= 1'b0;
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      checks++;
      if ({o2, o1, o0} !== 3'b000)
        begin errors++; $display("FAIL reset_hold t=%0d: out=%b expected 000", t, {o2, o1, o0}); end
      btn = 1'($urandom_range(0, 1));
    end
    btn   = 1'b0;
    reset = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      checks++;
      if ({o2, o1, o0} !== 3'b000)
        begin errors++; $display("FAIL reset_release t=%0d: out=%b expected 000", t, {o2, o1, o0}); end
    end
  endtask

  task automatic test_single_press();
    int p0[$], p2[$];
    btn = 1'b0;
    repeat (20) @(negedge clk);
    for (int t = 0; t < 70; t++) begin
      if (t > 0) @(negedge clk);
      checks++;
      if ({o2, o1, o0} !== exp_o)
        begin errors++; $display("FAIL model_single t=%0d: out=%b expected %b", t, {o2, o1, o0}, exp_o); end
      if (o0) p0.push_back(t);
      if (o2) p2.push_back(t);
      btn = (t < 50);
    end
    checks++;
    if (p0.size() != 1 || p0[0] != 3)
      begin errors++; $display("FAIL single_press_s2: pulses=%0d first=%0d expected 1 at 3", p0.size(), (p0.size() > 0) ? p0[0] : -1); end
    checks++;
    if (p2.size() != 1 || p2[0] != 5)
      begin errors++; $display("FAIL single_press_s4: pulses=%0d first=%0d expected 1 at 5", p2.size(), (p2.size() > 0) ? p2[0] : -1); end
  endtask

  task automatic test_back_to_back();
    int p0[$];
    btn = 1'b0;
    repeat (20) @(negedge clk);
    for (int t = 0; t < 30; t++) begin
      if (t > 0) @(negedge clk);
      checks++;
      if ({o2, o1, o0} !== exp_o)
        begin errors++; $display("FAIL model_b2b t=%0d: out=%b expected %b", t, {o2, o1, o0}, exp_o); end
      if (o0) p0.push_back(t);
      btn = (t <= 4) || (t >= 7 && t <= 10);
    end
    checks++;
    if (p0.size() != 2 || (p0.size() == 2 && p0[1] - p0[0] != 7))
      begin errors++; $display("FAIL back_to_back: pulses=%0d gap=%0d expected 2 pulses gap 7", p0.size(), (p0.size() == 2) ? p0[1] - p0[0] : -1); end
  endtask

  task automatic test_lockout();
    int p0[$], p1[$];
    btn = 1'b0;
    repeat (20) @(negedge clk);
    for (int t = 0; t < 30; t++) begin
      if (t > 0) @(negedge clk);
      checks++;
      if ({o2, o1, o0} !== exp_o)
        begin errors++; $display("FAIL model_lockout t=%0d: out=%b expected %b", t, {o2, o1, o0}, exp_o); end
      if (o0) p0.push_back(t);
      if (o1) p1.push_back(t);
      btn = (t <= 1) || (t >= 5 && t <= 7) || (t >= 9 && t <= 10);
    end
    checks++;
    if (p1.size() != 2 || (p1.size() == 2 && (p1[0] != 3 || p1[1] != 12)))
      begin errors++; $display("FAIL lockout_l8: pulses=%0d expected 2 at 3 and 12", p1.size()); end
    checks++;
    if (p0.size() != 3)
      begin errors++; $display("FAIL lockout_l0: pulses=%0d expected 3", p0.size()); end
  endtask

  task automatic test_reset_mid_lockout();
    int p1[$];
    btn = 1'b0;
    repeat (20) @(negedge clk);
    for (int t = 0; t < 25; t++) begin
      if (t > 0) @(negedge clk);
      checks++;
      if ({o2, o1, o0} !== exp_o)
        begin errors++; $display("FAIL model_rst_lock t=%0d: out=%b expected %b", t, {o2, o1, o0}, exp_o); end
      if (o1) p1.push_back(t);
      btn = (t <= 1) || (t >= 7 && t <= 9);
      if (t == 5) reset = 1'b0;
      if (t == 7) reset = 1'b1;
    end
    checks++;
    if (p1.size() != 2 || (p1.size() == 2 && (p1[0] != 3 || p1[1] != 10)))
      begin errors++; $display("FAIL reset_mid_lockout: pulses=%0d expected 2 at 3 and 10", p1.size()); end
  endtask

  task automatic test_release_high();
    int p0[$], p2[$];
    for (int t = 0; t < 35; t++) begin
      if (t > 0) @(negedge clk);
      checks++;
      if ({o2, o1, o0} !== exp_o)
        begin errors++; $display("FAIL model_rel_high t=%0d: out=%b expected %b", t, {o2, o1, o0}, exp_o); end
      if (o0) p0.push_back(t);
      if (o2) p2.push_back(t);
      if (t == 0) begin reset = 1'b0; btn = 1'b1; end
      if (t == 3) reset = 1'b1;
    end
    btn = 1'b0;
    checks++;
    if (p0.size() != 1 || p0[0] != 6)
      begin errors++; $display("FAIL release_high_s2: pulses=%0d first=%0d expected 1 at 6", p0.size(), (p0.size() > 0) ? p0[0] : -1); end
    checks++;
    if (p2.size() != 1 || p2[0] != 8)
      begin errors++; $display("FAIL release_high_s4: pulses=%0d first=%0d expected 1 at 8", p2.size(), (p2.size() > 0) ? p2[0] : -1); end
  endtask

  task automatic test_random();
    int hold = 0;
    int rcnt = 0;
    int pulses = 0;
    btn = 1'b0;
    repeat (20) @(negedge clk);
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      checks++;
      if ({o2, o1, o0} !== exp_o)
        begin errors++; $display("FAIL model_random t=%0d: out=%b expected %b", t, {o2, o1, o0}, exp_o); end
      pulses += int'(o0);
      if (!reset) begin
        rcnt--;
        if (rcnt == 0) reset = 1'b1;
      end else if ($urandom_range(0, 199) == 0) begin
        reset = 1'b0;
        rcnt  = int'($urandom_range(2, 4));
      end
      if (hold == 0) begin
        btn  = 1'($urandom_range(0, 1));
        hold = int'($urandom_range(1, 12));
      end
      hold--;
    end
    reset = 1'b1;
    checks++;
    if (pulses < 20)
      begin errors++; $display("FAIL random_activity: pulses=%0d expected at least 20", pulses); end
  endtask

  initial begin
    reset = 1'b0;
    btn   = 1'b0;
    test_reset();
    test_single_press();
    test_back_to_back();
    test_lockout();
    test_reset_mid_lockout();
    test_release_high();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
